// File: rtl/life_seq_ctrl_4x4.sv
// life_seq_ctrl_4x4: sequencer for the 4x4 life cell array.
// Loads a 16-bit seed one cell per cycle, then steps generations at a fixed
// rate until a generation limit, extinction, still life or user stop.
// Single scan shifts can be requested while idle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start (latch seed) or scan_req (one scan shift)
// LOAD   | writing seed cell idx (0..15), one write strobe per cycle
// WAIT   | inter-generation delay, timer counts PERIOD-1 down to 0
// STEP   | one-cycle run pulse, capture pre-step alive vector
// CHECK  | compare new generation against exit conditions
// DONE   | one-cycle done pulse, last busy cycle
module life_seq_ctrl_4x4 #(
    parameter int GEN_W  = 8,
    parameter int PERIOD = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [15:0]      i_pattern,
    input  logic [GEN_W-1:0] i_gens,
    input  logic             i_stop,
    input  logic             i_scan_req,
    input  logic [15:0]      i_alive,
    output logic [1:0]       o_row,
    output logic [1:0]       o_col,
    output logic             o_val,
    output logic             o_write_enb,
    output logic             o_scan,
    output logic             o_run,
    output logic             o_busy,
    output logic             o_done,
    output logic [GEN_W-1:0] o_gen_count,
    output logic             o_extinct,
    output logic             o_still
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_STEP  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] TIMER_LOAD = 8'(PERIOD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_pattern;
    logic [GEN_W-1:0] r_gens;
    logic [3:0]       r_idx;
    logic [7:0]       r_timer;
    logic [15:0]      r_alive_prev;

    logic             w_start_ok;
    logic             w_extinct_now;
    logic             w_still_now;
    logic             w_limit;
    logic [3:0]       w_load_idx;
    logic [15:0]      w_load_pat;

    logic [1:0]       w_row;
    logic [1:0]       w_col;
    logic             w_val;
    logic             w_write_enb;
    logic             w_scan;
    logic             w_run;
    logic             w_busy;
    logic             w_done;
    logic [GEN_W-1:0] w_gen_count;
    logic             w_extinct;
    logic             w_still;

    assign w_start_ok    = (r_state == S_IDLE) && i_start;
    assign w_extinct_now = (i_alive == 16'h0000);
    assign w_still_now   = (i_alive == r_alive_prev);
    assign w_limit       = (r_gens != '0) && (o_gen_count == r_gens);
    // Cell index and seed that the next LOAD cycle will present.
    assign w_load_idx    = (r_state == S_LOAD) ? (r_idx + 4'd1) : 4'd0;
    assign w_load_pat    = (r_state == S_IDLE) ? i_pattern : r_pattern;

    // State register plus sequencing datapath (seed latch, load index, timer, alive snapshot).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_gens       <= '0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_alive_prev <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_pattern <= i_pattern;
                r_gens    <= i_gens;
            end
            if (w_state_nxt == S_LOAD) begin
                r_idx <= w_load_idx;
            end
            if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT)) begin
                r_timer <= TIMER_LOAD;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer - 8'd1;
            end
            if (r_state == S_STEP) begin
                r_alive_prev <= i_alive;
            end
        end
    end

    // Next-state decode; stop wins over timer expiry in WAIT and is ignored in LOAD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:  if (r_idx == 4'd15) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_stop)                w_state_nxt = S_DONE;
                else if (r_timer == 8'd0)  w_state_nxt = S_STEP;
            end
            S_STEP:  w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_extinct_now || w_still_now || w_limit || i_stop) w_state_nxt = S_DONE;
                else                                                   w_state_nxt = S_WAIT;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        w_write_enb = (w_state_nxt == S_LOAD);
        w_row       = w_write_enb ? w_load_idx[1:0] : o_row;
        w_col       = w_write_enb ? w_load_idx[3:2] : o_col;
        w_val       = w_write_enb ? w_load_pat[w_load_idx] : o_val;
        w_scan      = (r_state == S_IDLE) && !i_start && i_scan_req;
        w_run       = (w_state_nxt == S_STEP);
        w_busy      = (w_state_nxt != S_IDLE);
        w_done      = (w_state_nxt == S_DONE);
        w_gen_count = o_gen_count;
        w_extinct   = o_extinct;
        w_still     = o_still;
        if (w_start_ok) begin
            w_gen_count = '0;
            w_extinct   = 1'b0;
            w_still     = 1'b0;
        end else if (r_state == S_STEP) begin
            w_gen_count = o_gen_count + GEN_W'(1);
        end else if (r_state == S_CHECK) begin
            if (w_extinct_now) w_extinct = 1'b1;
            if (w_still_now)   w_still   = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_row       <= '0;
            o_col       <= '0;
            o_val       <= 1'b0;
            o_write_enb <= 1'b0;
            o_scan      <= 1'b0;
            o_run       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_gen_count <= '0;
            o_extinct   <= 1'b0;
            o_still     <= 1'b0;
        end else begin
            o_row       <= w_row;
            o_col       <= w_col;
            o_val       <= w_val;
            o_write_enb <= w_write_enb;
            o_scan      <= w_scan;
            o_run       <= w_run;
            o_busy      <= w_busy;
            o_done      <= w_done;
            o_gen_count <= w_gen_count;
            o_extinct   <= w_extinct;
            o_still     <= w_still;
        end
    end

endmodule

// File: tb/tb_life_seq_ctrl_4x4.sv
// Bench for life_seq_ctrl_4x4 with a behavioural 4x4 life array attached.
module tb_life_seq_ctrl_4x4;

    localparam int GEN_W  = 8;
    localparam int PERIOD = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      pattern;
    logic [GEN_W-1:0] gens;
    logic             stop;
    logic             scan_req;
    logic [15:0]      alive;
    logic [1:0]       row;
    logic [1:0]       col;
    logic             val;
    logic             write_enb;
    logic             scan;
    logic             run;
    logic             busy;
    logic             done;
    logic [GEN_W-1:0] gen_count;
    logic             extinct;
    logic             still;

    life_seq_ctrl_4x4 #(.GEN_W(GEN_W), .PERIOD(PERIOD)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_pattern   (pattern),
        .i_gens      (gens),
        .i_stop      (stop),
        .i_scan_req  (scan_req),
        .i_alive     (alive),
        .o_row       (row),
        .o_col       (col),
        .o_val       (val),
        .o_write_enb (write_enb),
        .o_scan      (scan),
        .o_run       (run),
        .o_busy      (busy),
        .o_done      (done),
        .o_gen_count (gen_count),
        .o_extinct   (extinct),
        .o_still     (still)
    );

    always #5 clk = ~clk;

    // One life generation on a 4x4 board with dead cells beyond the edges.
    function automatic logic [15:0] life_next(input logic [15:0] p);
        logic [15:0] q;
        int n, cc, rr;
        q = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                n = 0;
                for (int dc = -1; dc <= 1; dc++) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        cc = c + dc;
                        rr = r + dr;
                        if ((dc != 0 || dr != 0) && cc >= 0 && cc < 4 && rr >= 0 && rr < 4)
                            if (p[cc*4 + rr]) n++;
                    end
                end
                q[c*4 + r] = (n == 3) || (p[c*4 + r] && n == 2);
            end
        end
        return q;
    endfunction

    // Array model: write port, generation step, scan rotate.
    logic [15:0] arr;
    assign alive = arr;
    always @(posedge clk) begin
        if (reset)          arr <= '0;
        else if (write_enb) arr[{col, row}] <= val;
        else if (run)       arr <= life_next(arr);
        else if (scan)      arr <= {arr[14:0], arr[15]};
    end

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int done_cyc;
    int scan_n;
    int wr_addr[$];
    bit wr_val[$];
    int run_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (write_enb) begin
            wr_addr.push_back(int'({col, row}));
            wr_val.push_back(val);
        end
        if (run)  run_cyc.push_back(cyc);
        if (scan) scan_n++;
        if (done) done_cyc = cyc;
    endtask

    task automatic do_start(input logic [15:0] p, input logic [GEN_W-1:0] g);
        wr_addr.delete();
        wr_val.delete();
        run_cyc.delete();
        done_cyc  = -1;
        pattern   = p;
        gens      = g;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_in_done", busy, 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    // Reference: run generations from the seed until a stop condition.
    task automatic ref_run(input logic [15:0] p, input int g,
                           output int cnt, output bit ext, output bit st);
        logic [15:0] cur, nxt;
        cur = p;
        cnt = 0;
        ext = 0;
        st  = 0;
        for (int k = 0; k < 300; k++) begin
            nxt = life_next(cur);
            cnt++;
            ext = (nxt == 16'h0);
            st  = (nxt == cur);
            if (ext || st || (g != 0 && cnt == g)) break;
            cur = nxt;
        end
    endtask

    task automatic check_load(input string tag, input logic [15:0] p);
        logic [15:0] got;
        bit order_ok;
        got = '0;
        order_ok = 1;
        for (int k = 0; k < wr_addr.size(); k++) begin
            if (wr_addr[k] != k) order_ok = 0;
            got[wr_addr[k][3:0]] = wr_val[k];
        end
        chk({tag, "_nwrites"}, wr_addr.size(), 16);
        chk({tag, "_order"}, order_ok, 1);
        chk({tag, "_loaded"}, got, p);
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] p, input int g);
        int ecnt;
        bit eext, est;
        ref_run(p, g, ecnt, eext, est);
        do_start(p, GEN_W'(g));
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_first_write"}, write_enb, 1);
        wait_done(600);
        check_load(tag, p);
        chk({tag, "_gen_count"}, gen_count, ecnt);
        chk({tag, "_extinct"}, extinct, eext);
        chk({tag, "_still"}, still, est);
        chk({tag, "_nruns"}, run_cyc.size(), ecnt);
        if (run_cyc.size() > 0)
            chk({tag, "_first_run"}, run_cyc[0] - start_cyc, 16 + PERIOD + 1);
        for (int k = 1; k < run_cyc.size(); k++)
            chk({tag, "_spacing"}, run_cyc[k] - run_cyc[k-1], PERIOD + 2);
        chk({tag, "_done_time"}, done_cyc - start_cyc, 16 + PERIOD + 1 + (PERIOD + 2) * (ecnt - 1) + 2);
    endtask

    initial begin
        logic [15:0] rp;
        int rg;
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        gens     = '0;
        stop     = 1'b0;
        scan_req = 1'b0;
        scan_n   = 0;
        done_cyc = -1;
        repeat (3) tick();
        chk("rst_write_enb", write_enb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {row, col, val, scan, run, done, extinct, still}, 0);
        chk("rst_gen_count", gen_count, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Reset held two cycles in the middle of LOAD.
        do_start(16'h0070, 0);
        repeat (4) tick();
        chk("midload_we", write_enb, 1);
        reset = 1'b1;
        tick();
        chk("rst1_we", write_enb, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_we_run_scan", {write_enb, run, scan}, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_gen_count", gen_count, 0);

        // Block: still life after one generation.
        run_and_check("block", 16'h0660, 5);
        chk("block_still_k", {still, extinct, gen_count}, {1'b1, 1'b0, 8'd1});

        // Blinker with a limit of 4.
        run_and_check("blinker", 16'h0070, 4);
        chk("blinker_k", {still, extinct, gen_count}, {1'b0, 1'b0, 8'd4});

        // Lone cell dies.
        run_and_check("lone", 16'h0001, 0);
        chk("lone_k", {still, extinct, gen_count}, {1'b0, 1'b1, 8'd1});

        // Blinker unlimited, stop raised in WAIT after the second generation.
        do_start(16'h0070, 0);
        for (int n = 0; n < 200 && run_cyc.size() < 2; n++) tick();
        chk("stop_two_runs", run_cyc.size(), 2);
        tick();
        tick();
        stop = 1'b1;
        tick();
        chk("stop_done_next", done, 1);
        stop = 1'b0;
        chk("stop_gen_count", gen_count, 2);
        repeat (8) tick();
        chk("stop_no_more_runs", run_cyc.size(), 2);
        chk("stop_flags", {extinct, still}, 0);
        chk("stop_idle", busy, 0);

        // Scan request in IDLE.
        scan_n = 0;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        chk("scan_high", scan, 1);
        tick();
        chk("scan_one_cycle", scan, 0);
        chk("scan_count", scan_n, 1);

        // start and scan_req together, then start while busy.
        scan_n = 0;
        scan_req = 1'b1;
        do_start(16'h0660, 5);
        scan_req = 1'b0;
        chk("prio_load", write_enb, 1);
        chk("prio_no_scan", scan, 0);
        tick();
        tick();
        start   = 1'b1;
        pattern = 16'hFFFF;
        gens    = 8'd1;
        scan_req = 1'b1;
        tick();
        start    = 1'b0;
        scan_req = 1'b0;
        wait_done(200);
        check_load("busy_start", 16'h0660);
        chk("busy_start_still", still, 1);
        chk("busy_start_gc", gen_count, 1);
        chk("busy_no_scan", scan_n, 0);

        // Randomized seeds and limits against the reference model.
        for (int it = 0; it < 8; it++) begin
            rp = 16'($urandom);
            rg = $urandom_range(1, 6);
            run_and_check("rand", rp, rg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
